// File: rtl/chain_dp_pkg.sv
// chain_dp_pkg: shared types, sizes and helpers for the chaining DP controller.
//   WIN       - predecessor window depth (power of 2)
//   SCORE_LAT - cycles from scorer operands to the matching sc_result
//   MAX_DIST  - largest reference gap for an eligible pair
//   IDX_W     - anchor index width
// Optional feature macro (used by chain_dp_ctrl): CHAIN_DP_STATS_EN.
package chain_dp_pkg;

    localparam int unsigned WIN       = 16;
    localparam int unsigned SCORE_LAT = 12;
    localparam int unsigned MAX_DIST  = 5000;
    localparam int unsigned IDX_W     = 16;
    localparam int unsigned K_W       = $clog2(WIN);
    localparam int unsigned CNT_W     = $clog2(WIN + 1);

    localparam logic [IDX_W-1:0]  NO_PRED   = '1;
    localparam logic signed [31:0] INT32_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] INT32_MIN = 32'sh8000_0000;

    typedef struct packed {
        logic [31:0] rx;
        logic [31:0] qx;
        logic [31:0] w;
    } anchor_t;

    typedef struct packed {
        logic [31:0]        rx;
        logic [31:0]        qx;
        logic signed [31:0] f;
        logic [IDX_W-1:0]   idx;
    } win_entry_t;

    typedef struct packed {
        logic           valid;
        logic [K_W-1:0] k;
        logic           elig;
    } tag_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_EMIT
    } state_e;

    // Signed 32-bit add evaluated in 33 bits and clamped to the INT32 range.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        logic [32:0]        s;
        logic signed [31:0] r;
        s = {a[31], a} + {b[31], b};
        case (s[32:31])
            2'b01:   r = INT32_MAX;
            2'b10:   r = INT32_MIN;
            default: r = signed'(s[31:0]);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/chain_win_buf.sv
// chain_win_buf: circular window of the most recent WIN chained anchors.
//   clr            - empties the window (count to zero), wins over a write's count bump
//   wr_en/wr_data  - writes the newest entry at the head, overwriting the oldest when full
//   rd_a_k         - relative index (0 = newest) returning rx/qx for operand issue
//   rd_b_k         - relative index (0 = newest) returning f/idx for score collection
//   cnt            - number of valid entries, saturating at WIN
module chain_win_buf
    import chain_dp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               wr_en,
    input  win_entry_t         wr_data,
    input  logic [K_W-1:0]     rd_a_k,
    output logic [31:0]        rd_a_rx,
    output logic [31:0]        rd_a_qx,
    input  logic [K_W-1:0]     rd_b_k,
    output logic signed [31:0] rd_b_f,
    output logic [IDX_W-1:0]   rd_b_idx,
    output logic [CNT_W-1:0]   cnt
);

    win_entry_t         mem_q [WIN];
    win_entry_t         mem_d [WIN];
    logic [K_W-1:0]     head_q, head_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [K_W-1:0]     slot_a, slot_b;

    // head points at the next free slot, so the newest entry sits at head-1.
    assign slot_a   = K_W'(head_q - K_W'(1) - rd_a_k);
    assign slot_b   = K_W'(head_q - K_W'(1) - rd_b_k);
    assign rd_a_rx  = mem_q[slot_a].rx;
    assign rd_a_qx  = mem_q[slot_a].qx;
    assign rd_b_f   = mem_q[slot_b].f;
    assign rd_b_idx = mem_q[slot_b].idx;
    assign cnt      = cnt_q;

    // Next-state for storage, head and saturating count.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        cnt_d  = cnt_q;
        if (wr_en) begin
            mem_d[head_q] = wr_data;
            head_d        = K_W'(head_q + 1'b1);
            if (cnt_q != CNT_W'(WIN)) begin
                cnt_d = CNT_W'(cnt_q + 1'b1);
            end
        end
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < WIN; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/chain_dp_ctrl.sv
// chain_dp_ctrl: initiator/consumer around the anchor-pair scorer for chaining DP.
// Each accepted anchor is scored against up to WIN predecessors (newest first), the
// scores are folded into f(i) = max(w_i, max_j f(j) + score(i,j)) and emitted with
// the winning predecessor index.
//   clk, reset              - clock, synchronous active-high reset
//   cfg_w_avg               - average seed length passed to the scorer
//   in_valid/in_ready       - anchor handshake (in_rx, in_qx, in_w, in_last)
//   sc_riX..sc_W_avg        - registered scorer operands, one pair per ISSUE cycle
//   sc_result               - signed scorer output, SCORE_LAT cycles after operands
//   out_valid/out_ready     - result handshake (out_f, out_p, out_idx)
// Optional macro CHAIN_DP_STATS_EN adds stat_pairs and stat_rejected counters.
module chain_dp_ctrl
    import chain_dp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        cfg_w_avg,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_rx,
    input  logic [31:0]        in_qx,
    input  logic [31:0]        in_w,
    input  logic               in_last,
    output logic [31:0]        sc_riX,
    output logic [31:0]        sc_riY,
    output logic [31:0]        sc_qiX,
    output logic [31:0]        sc_qiY,
    output logic [31:0]        sc_W,
    output logic [31:0]        sc_W_avg,
    input  logic signed [31:0] sc_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_f,
    output logic [IDX_W-1:0]   out_p,
    output logic [IDX_W-1:0]   out_idx
`ifdef CHAIN_DP_STATS_EN
    ,
    output logic [31:0]        stat_pairs,
    output logic [31:0]        stat_rejected
`endif
);

    state_e             state_q, state_d;
    anchor_t            cur_q, cur_d;
    logic               last_q, last_d;
    logic signed [31:0] best_q, best_d;
    logic [IDX_W-1:0]   bp_q, bp_d;
    logic [CNT_W-1:0]   k_q, k_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    tag_t               tag_q [SCORE_LAT];
    tag_t               tag_d [SCORE_LAT];

    logic [31:0]        sc_rix_q, sc_rix_d;
    logic [31:0]        sc_riy_q, sc_riy_d;
    logic [31:0]        sc_qix_q, sc_qix_d;
    logic [31:0]        sc_qiy_q, sc_qiy_d;
    logic [31:0]        sc_w_q, sc_w_d;
    logic [31:0]        sc_w_avg_q, sc_w_avg_d;

    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic signed [31:0] out_f_q, out_f_d;
    logic [IDX_W-1:0]   out_p_q, out_p_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;

`ifdef CHAIN_DP_STATS_EN
    logic [31:0]        stat_pairs_q, stat_pairs_d;
    logic [31:0]        stat_rejected_q, stat_rejected_d;
`endif

    // Window interface.
    logic               win_clr, win_wr;
    win_entry_t         win_wdata;
    logic [K_W-1:0]     rd_a_k, rd_b_k;
    logic [31:0]        rd_a_rx, rd_a_qx;
    logic signed [31:0] rd_b_f;
    logic [IDX_W-1:0]   rd_b_idx;
    logic [CNT_W-1:0]   cnt;

    tag_t               exit_tag;
    logic signed [31:0] cand;
    logic               elig;
    logic               pipe_busy;

    chain_win_buf u_win (
        .clk      (clk),
        .reset    (reset),
        .clr      (win_clr),
        .wr_en    (win_wr),
        .wr_data  (win_wdata),
        .rd_a_k   (rd_a_k),
        .rd_a_rx  (rd_a_rx),
        .rd_a_qx  (rd_a_qx),
        .rd_b_k   (rd_b_k),
        .rd_b_f   (rd_b_f),
        .rd_b_idx (rd_b_idx),
        .cnt      (cnt)
    );

    // Operand read: newest entry when accepting, otherwise the pair after the one on sc_*.
    assign rd_a_k    = (state_q == S_IDLE) ? '0 : K_W'(k_q + 1'b1);
    assign exit_tag  = tag_q[SCORE_LAT-1];
    assign rd_b_k    = exit_tag.k;
    assign cand      = sat_add(rd_b_f, sc_result);
    assign win_wdata = '{rx: cur_q.rx, qx: cur_q.qx, f: best_q, idx: idx_q};

    // Eligibility of the pair currently on the scorer operands.
    assign elig = (sc_rix_q > sc_riy_q) && (sc_qix_q > sc_qiy_q) &&
                  ((sc_rix_q - sc_riy_q) <= 32'(MAX_DIST));

    // Any tag still in flight behind the one exiting this cycle.
    always_comb begin
        pipe_busy = 1'b0;
        for (int unsigned i = 0; i + 1 < SCORE_LAT; i++) begin
            pipe_busy = pipe_busy | tag_q[i].valid;
        end
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        best_d      = best_q;
        bp_d        = bp_q;
        k_d         = k_q;
        idx_d       = idx_q;
        sc_rix_d    = sc_rix_q;
        sc_riy_d    = sc_riy_q;
        sc_qix_d    = sc_qix_q;
        sc_qiy_d    = sc_qiy_q;
        sc_w_d      = sc_w_q;
        sc_w_avg_d  = sc_w_avg_q;
        out_valid_d = out_valid_q;
        out_f_d     = out_f_q;
        out_p_d     = out_p_q;
        out_idx_d   = out_idx_q;
        win_wr      = 1'b0;
        win_clr     = 1'b0;
`ifdef CHAIN_DP_STATS_EN
        stat_pairs_d    = stat_pairs_q;
        stat_rejected_d = stat_rejected_q;
        if (exit_tag.valid && !exit_tag.elig) begin
            stat_rejected_d = stat_rejected_q + 32'd1;
        end
`endif

        tag_d[0] = '0;
        for (int unsigned i = 1; i < SCORE_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        // Fold the exiting score; strict compare keeps the more recent predecessor on ties.
        if ((state_q == S_ISSUE || state_q == S_DRAIN) &&
            exit_tag.valid && exit_tag.elig && (cand > best_q)) begin
            best_d = cand;
            bp_d   = rd_b_idx;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    cur_d  = '{rx: in_rx, qx: in_qx, w: in_w};
                    last_d = in_last;
                    best_d = signed'(in_w);
                    bp_d   = NO_PRED;
                    k_d    = '0;
                    if (cnt == '0) begin
                        state_d     = S_EMIT;
                        out_valid_d = 1'b1;
                        out_f_d     = signed'(in_w);
                        out_p_d     = NO_PRED;
                        out_idx_d   = idx_q;
                    end else begin
                        // First pair goes out on sc_* during the first ISSUE cycle.
                        state_d    = S_ISSUE;
                        sc_rix_d   = in_rx;
                        sc_riy_d   = rd_a_rx;
                        sc_qix_d   = in_qx;
                        sc_qiy_d   = rd_a_qx;
                        sc_w_d     = in_w;
                        sc_w_avg_d = cfg_w_avg;
                    end
                end
            end
            S_ISSUE: begin
                tag_d[0] = '{valid: 1'b1, k: K_W'(k_q), elig: elig};
                k_d      = CNT_W'(k_q + 1'b1);
`ifdef CHAIN_DP_STATS_EN
                stat_pairs_d = stat_pairs_q + 32'd1;
`endif
                if (CNT_W'(k_q + 1'b1) == cnt) begin
                    state_d = S_DRAIN;
                end else begin
                    sc_rix_d   = cur_q.rx;
                    sc_riy_d   = rd_a_rx;
                    sc_qix_d   = cur_q.qx;
                    sc_qiy_d   = rd_a_qx;
                    sc_w_d     = cur_q.w;
                    sc_w_avg_d = cfg_w_avg;
                end
            end
            S_DRAIN: begin
                if (!pipe_busy) begin
                    state_d     = S_EMIT;
                    out_valid_d = 1'b1;
                    out_f_d     = best_d;
                    out_p_d     = bp_d;
                    out_idx_d   = idx_q;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    win_wr      = 1'b1;
                    win_clr     = last_q;
                    out_valid_d = 1'b0;
                    idx_d       = last_q ? '0 : IDX_W'(idx_q + 1'b1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            last_q      <= 1'b0;
            best_q      <= '0;
            bp_q        <= '0;
            k_q         <= '0;
            idx_q       <= '0;
            for (int unsigned i = 0; i < SCORE_LAT; i++) begin
                tag_q[i] <= '0;
            end
            sc_rix_q    <= '0;
            sc_riy_q    <= '0;
            sc_qix_q    <= '0;
            sc_qiy_q    <= '0;
            sc_w_q      <= '0;
            sc_w_avg_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
            out_p_q     <= '0;
            out_idx_q   <= '0;
`ifdef CHAIN_DP_STATS_EN
            stat_pairs_q    <= '0;
            stat_rejected_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            best_q      <= best_d;
            bp_q        <= bp_d;
            k_q         <= k_d;
            idx_q       <= idx_d;
            for (int unsigned i = 0; i < SCORE_LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
            sc_rix_q    <= sc_rix_d;
            sc_riy_q    <= sc_riy_d;
            sc_qix_q    <= sc_qix_d;
            sc_qiy_q    <= sc_qiy_d;
            sc_w_q      <= sc_w_d;
            sc_w_avg_q  <= sc_w_avg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_f_q     <= out_f_d;
            out_p_q     <= out_p_d;
            out_idx_q   <= out_idx_d;
`ifdef CHAIN_DP_STATS_EN
            stat_pairs_q    <= stat_pairs_d;
            stat_rejected_q <= stat_rejected_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_f     = out_f_q;
    assign out_p     = out_p_q;
    assign out_idx   = out_idx_q;
    assign sc_riX    = sc_rix_q;
    assign sc_riY    = sc_riy_q;
    assign sc_qiX    = sc_qix_q;
    assign sc_qiY    = sc_qiy_q;
    assign sc_W      = sc_w_q;
    assign sc_W_avg  = sc_w_avg_q;
`ifdef CHAIN_DP_STATS_EN
    assign stat_pairs    = stat_pairs_q;
    assign stat_rejected = stat_rejected_q;
`endif

endmodule

// File: tb/tb_chain_dp_ctrl.sv
// tb_chain_dp_ctrl: directed bench for chain_dp_ctrl with a pipelined scorer stub.
// The stub returns stub_val (or alt_val when the predecessor rx equals alt_rx)
// exactly SCORE_LAT cycles after the operands appear on sc_*.
module tb_chain_dp_ctrl;
    import chain_dp_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [31:0]        cfg_w_avg = 32'd15;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [31:0]        in_rx = '0;
    logic [31:0]        in_qx = '0;
    logic [31:0]        in_w = '0;
    logic               in_last = 1'b0;
    logic [31:0]        sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W, sc_W_avg;
    logic signed [31:0] sc_result;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [31:0] out_f;
    logic [IDX_W-1:0]   out_p;
    logic [IDX_W-1:0]   out_idx;
`ifdef CHAIN_DP_STATS_EN
    logic [31:0]        stat_pairs, stat_rejected;
    logic [31:0]        rej_before;
`endif

    logic signed [31:0] stub_val = 32'sd10;
    logic [31:0]        alt_rx = 32'hFFFF_FFFF;
    logic signed [31:0] alt_val = 32'sd0;
    logic signed [31:0] sc_pipe [SCORE_LAT];

    int unsigned cyc = 0;
    int unsigned ea = 0;
    int          passed = 0;
    int          failed = 0;
    int          total = 0;

    localparam logic [15:0] NP = 16'hFFFF;

    chain_dp_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_w_avg (cfg_w_avg),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rx     (in_rx),
        .in_qx     (in_qx),
        .in_w      (in_w),
        .in_last   (in_last),
        .sc_riX    (sc_riX),
        .sc_riY    (sc_riY),
        .sc_qiX    (sc_qiX),
        .sc_qiY    (sc_qiY),
        .sc_W      (sc_W),
        .sc_W_avg  (sc_W_avg),
        .sc_result (sc_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_f     (out_f),
        .out_p     (out_p),
        .out_idx   (out_idx)
`ifdef CHAIN_DP_STATS_EN
        ,
        .stat_pairs    (stat_pairs),
        .stat_rejected (stat_rejected)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scorer stub: fixed-latency pipeline keyed on the operands on sc_*.
    always @(posedge clk) begin
        sc_pipe[0] <= (sc_riY == alt_rx) ? alt_val : stub_val;
        for (int i = 1; i < SCORE_LAT; i++) sc_pipe[i] <= sc_pipe[i-1];
    end
    assign sc_result = sc_pipe[SCORE_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] rx, input logic [31:0] qx,
                        input logic [31:0] w, input logic last);
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_rx    = rx;
        in_qx    = qx;
        in_w     = w;
        in_last  = last;
        @(posedge clk);
        #1;
        ea       = cyc;
        in_valid = 1'b0;
    endtask

    // Wait for a result, check it, and (with out_ready high) let it be consumed.
    task automatic get_out(input string tag, input logic [31:0] ef, input logic [15:0] ep,
                           input logic [15:0] ei, input int el);
        int n = 0;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (el > 0) chk({tag, "_lat"}, cyc - ea + 1, el);
        chk({tag, "_f"}, out_f, ef);
        chk({tag, "_p"}, {16'd0, out_p}, {16'd0, ep});
        chk({tag, "_idx"}, {16'd0, out_idx}, {16'd0, ei});
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < SCORE_LAT; i++) sc_pipe[i] = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_f", out_f, 32'd0);
        chk("rst_out_p", {16'd0, out_p}, 32'd0);
        chk("rst_out_idx", {16'd0, out_idx}, 32'd0);
        chk("rst_sc_riX", sc_riX, 32'd0);
        chk("rst_sc_W", sc_W, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready_rise", {31'd0, in_ready}, 32'd1);

        // Single anchor ending a read, then a fresh read starts at idx 0.
        stub_val = 32'sd10;
        send(32'd100, 32'd200, 32'd15, 1'b1);
        get_out("single", 32'd15, NP, 16'd0, 1);
        send(32'd100, 32'd200, 32'd15, 1'b0);
        get_out("first", 32'd15, NP, 16'd0, 1);

        // One eligible predecessor.
        send(32'd150, 32'd260, 32'd15, 1'b1);
        get_out("onepred", 32'd25, 16'd0, 16'd1, 14);
        chk("onepred_W_avg", sc_W_avg, 32'd15);

        // Query position not increasing: ineligible.
        send(32'd100, 32'd200, 32'd15, 1'b0);
        get_out("q_a", 32'd15, NP, 16'd0, 1);
`ifdef CHAIN_DP_STATS_EN
        rej_before = stat_rejected;
`endif
        send(32'd150, 32'd190, 32'd15, 1'b1);
        get_out("q_b", 32'd15, NP, 16'd1, 14);
`ifdef CHAIN_DP_STATS_EN
        chk("q_rejected", stat_rejected - rej_before, 32'd1);
`endif

        // Reference gap 6000 is too far; gap 5000 is exactly allowed.
        send(32'd100, 32'd200, 32'd15, 1'b0);
        get_out("g6_a", 32'd15, NP, 16'd0, 1);
        send(32'd6100, 32'd300, 32'd15, 1'b1);
        get_out("g6_b", 32'd15, NP, 16'd1, 14);
        send(32'd100, 32'd200, 32'd15, 1'b0);
        get_out("g5_a", 32'd15, NP, 16'd0, 1);
        send(32'd5100, 32'd300, 32'd15, 1'b1);
        get_out("g5_b", 32'd25, 16'd0, 16'd1, 14);

        // Tie between two predecessors: the newer one wins.
        send(32'd100, 32'd100, 32'd30, 1'b0);
        get_out("tie_a", 32'd30, NP, 16'd0, 1);
        stub_val = -32'sd100;
        send(32'd200, 32'd200, 32'd30, 1'b0);
        get_out("tie_b", 32'd30, NP, 16'd1, 14);
        stub_val = 32'sd10;
        send(32'd300, 32'd300, 32'd10, 1'b1);
        get_out("tie_c", 32'd40, 16'd1, 16'd2, 15);

        // Distinct per-predecessor scores: the older one wins here.
        send(32'd100, 32'd100, 32'd30, 1'b0);
        get_out("pick_a", 32'd30, NP, 16'd0, 1);
        stub_val = -32'sd100;
        send(32'd200, 32'd200, 32'd30, 1'b0);
        get_out("pick_b", 32'd30, NP, 16'd1, 14);
        stub_val = 32'sd10;
        alt_rx   = 32'd100;
        alt_val  = 32'sd50;
        send(32'd300, 32'd300, 32'd10, 1'b1);
        get_out("pick_c", 32'd80, 16'd0, 16'd2, 15);
        alt_rx   = 32'hFFFF_FFFF;

        // Saturation at INT32_MAX.
        send(32'd100, 32'd100, 32'h7FFF_FFFA, 1'b0);
        get_out("sat_a", 32'h7FFF_FFFA, NP, 16'd0, 1);
        stub_val = 32'sd100;
        send(32'd200, 32'd200, 32'd15, 1'b1);
        get_out("sat_b", 32'h7FFF_FFFF, 16'd0, 16'd1, 14);

        // Window wrap: anchor 0 scores hugely but must drop out after 16 newer anchors.
        stub_val = -32'sd1000;
        alt_rx   = 32'd1000;
        alt_val  = 32'sd100000;
        for (int n = 0; n < 19; n++) begin
            logic [31:0] ef;
            logic [15:0] ep;
            int          el;
            ef = (n == 0) ? 32'd1 : (n <= 16) ? 32'd100001 : 32'd99001;
            ep = (n == 0) ? NP : (n <= 16) ? 16'd0 : 16'd16;
            el = (n == 0) ? 1 : ((n < 16) ? n : 16) + 13;
            send(32'(1000 + 10 * n), 32'(1000 + 10 * n), 32'd1, n == 18);
            get_out($sformatf("win%0d", n), ef, ep, 16'(n), el);
        end
        alt_rx   = 32'hFFFF_FFFF;
        stub_val = 32'sd10;

        // Backpressure: result held, no new anchor accepted.
        out_ready = 1'b0;
        send(32'd500, 32'd500, 32'd7, 1'b1);
        get_out("bp", 32'd7, NP, 16'd0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("bp_f%0d", i), out_f, 32'd7);
            chk($sformatf("bp_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_released", {31'd0, out_valid}, 32'd0);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd1);

        // Reset pulsed while draining: nothing emerges, the window is empty afterwards.
        send(32'd100, 32'd200, 32'd15, 1'b0);
        get_out("rd_a", 32'd15, NP, 16'd0, 1);
        send(32'd150, 32'd260, 32'd15, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rd_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rd_in_ready", {31'd0, in_ready}, 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (out_valid === 1'b1) seen = 1'b1;
            end
            chk("rd_no_stale", {31'd0, seen}, 32'd0);
        end
        send(32'd700, 32'd800, 32'd9, 1'b1);
        get_out("rd_next", 32'd9, NP, 16'd0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
